// File: rtl/systolic_mac_node_v2_if.sv
// -----------------------------------------------------------------------------
// systolic_mac_node_v2_if
// Bundles the per-cell data and weight signals of one systolic MAC node.
//
// Signals (directions seen from the node, i.e. the slave modport):
//   enable_in        in   pipeline advance; 0 holds every register
//   weight_valid_in  in   load weight_in into the shadow weight
//   weight_in        in   weight for the shadow register / chain
//   weight_swap_in   in   copy shadow weight to active weight
//   weight_out       out  shadow weight, to the cell below
//   act_valid_in     in   activation_in / partial_sum_in are valid
//   activation_in    in   activation from the left cell
//   partial_sum_in   in   partial sum from the cell above
//   act_valid_out    out  activation_out is valid
//   activation_out   out  activation to the right cell
//   psum_valid_out   out  partial_sum_out is valid
//   partial_sum_out  out  partial sum to the cell below
//
// The master modport is the driving side (neighbour cell or test harness).
// -----------------------------------------------------------------------------
interface systolic_mac_node_v2_if #(
    parameter int DATA_WIDTH     = 16,
    parameter int PSUM_IN_WIDTH  = 16,
    parameter int PSUM_OUT_WIDTH = PSUM_IN_WIDTH + 1
);
    logic                              enable_in;
    logic                              weight_valid_in;
    logic signed [DATA_WIDTH-1:0]      weight_in;
    logic                              weight_swap_in;
    logic signed [DATA_WIDTH-1:0]      weight_out;
    logic                              act_valid_in;
    logic signed [DATA_WIDTH-1:0]      activation_in;
    logic signed [PSUM_IN_WIDTH-1:0]   partial_sum_in;
    logic                              act_valid_out;
    logic signed [DATA_WIDTH-1:0]      activation_out;
    logic                              psum_valid_out;
    logic signed [PSUM_OUT_WIDTH-1:0]  partial_sum_out;

    modport master (
        output enable_in,
        output weight_valid_in,
        output weight_in,
        output weight_swap_in,
        input  weight_out,
        output act_valid_in,
        output activation_in,
        output partial_sum_in,
        input  act_valid_out,
        input  activation_out,
        input  psum_valid_out,
        input  partial_sum_out
    );

    modport slave (
        input  enable_in,
        input  weight_valid_in,
        input  weight_in,
        input  weight_swap_in,
        output weight_out,
        input  act_valid_in,
        input  activation_in,
        input  partial_sum_in,
        output act_valid_out,
        output activation_out,
        output psum_valid_out,
        output partial_sum_out
    );
endinterface

// File: rtl/systolic_mac_node_v2.sv
// -----------------------------------------------------------------------------
// systolic_mac_node_v2
// Weight-stationary processing element for the systolic array. Multiplies the
// incoming signed fixed-point activation by the active weight, rescales
// (truncate or round half up), saturates to DATA_WIDTH, adds the partial sum
// from above and forwards the activation right and the sum down.
// Weights are double buffered: a shadow register (also driven down the weight
// daisy-chain on weight_out) and an active register loaded by a swap.
//
// Ports:
//   clk_in        in   clock, rising edge
//   rst_n_in      in   asynchronous active-low reset (internally released
//                      synchronously)
//   node          slave modport of systolic_mac_node_v2_if (data, weights,
//                      valids, enable)
//   sat_clear_in  in   clear the sticky saturation flag   (optional)
//   sat_flag_out  out  sticky saturation flag             (optional)
//
// Build option:
//   SYSTOLIC_NODE_SAT_FLAG_EN  when defined, adds sat_clear_in/sat_flag_out and
//                              the sticky flag logic. Datapath is unchanged.
//
// Latency: activation_out two edges after the input cycle, partial_sum_out
// three edges after.
// -----------------------------------------------------------------------------
module systolic_mac_node_v2 #(
    parameter int DATA_WIDTH     = 16,
    parameter int FRAC_BITS      = 10,
    parameter int PSUM_IN_WIDTH  = 16,
    parameter int PSUM_OUT_WIDTH = PSUM_IN_WIDTH + 1,
    parameter int ROUND_NEAREST  = 0
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    systolic_mac_node_v2_if.slave  node
`ifdef SYSTOLIC_NODE_SAT_FLAG_EN
    ,
    input  logic                   sat_clear_in,
    output logic                   sat_flag_out
`endif
);

    localparam int PROD_WIDTH = 2 * DATA_WIDTH;
    // One guard bit so adding the rounding constant can never overflow.
    localparam int EXT_WIDTH  = PROD_WIDTH + 1;

    localparam logic signed [EXT_WIDTH-1:0] ROUND_HALF =
        (ROUND_NEAREST != 0 && FRAC_BITS > 0)
            ? (EXT_WIDTH'(1) << ((FRAC_BITS > 0) ? FRAC_BITS - 1 : 0))
            : '0;

    localparam logic signed [EXT_WIDTH-1:0] SAT_MAX =
        {{(EXT_WIDTH - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [EXT_WIDTH-1:0] SAT_MIN =
        {{(EXT_WIDTH - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

    // Arithmetic right shift by FRAC_BITS, optionally rounding half up first.
    function automatic logic signed [EXT_WIDTH-1:0] rescale(
        input logic signed [PROD_WIDTH-1:0] prod
    );
        logic signed [EXT_WIDTH-1:0] ext;
        ext = EXT_WIDTH'(prod) + ROUND_HALF;
        return ext >>> FRAC_BITS;
    endfunction

    // Clamp to the signed DATA_WIDTH range.
    function automatic logic signed [DATA_WIDTH-1:0] saturate(
        input logic signed [EXT_WIDTH-1:0] v
    );
        logic signed [EXT_WIDTH-1:0] c;
        if (v > SAT_MAX) begin
            c = SAT_MAX;
        end else if (v < SAT_MIN) begin
            c = SAT_MIN;
        end else begin
            c = v;
        end
        return c[DATA_WIDTH-1:0];
    endfunction

`ifdef SYSTOLIC_NODE_SAT_FLAG_EN
    function automatic logic saturates(
        input logic signed [EXT_WIDTH-1:0] v
    );
        return (v > SAT_MAX) || (v < SAT_MIN);
    endfunction
`endif

    // Reset synchronizer: assertion is immediate, release is aligned to clk_in.
    logic rst_meta;
    logic rst_core_n;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rst_meta   <= 1'b0;
            rst_core_n <= 1'b0;
        end else begin
            rst_meta   <= 1'b1;
            rst_core_n <= rst_meta;
        end
    end

    logic                             enable;
    assign enable = node.enable_in;

    // Weight buffers
    logic signed [DATA_WIDTH-1:0]     shadow_w;
    logic signed [DATA_WIDTH-1:0]     active_w;
    logic                             swap_p0;
    logic signed [DATA_WIDTH-1:0]     swap_w_p0;

    // Datapath pipeline
    logic                             vld_p0;
    logic signed [DATA_WIDTH-1:0]     act_p0;
    logic signed [PSUM_IN_WIDTH-1:0]  psum_p0;
    logic                             vld_p1;
    logic signed [DATA_WIDTH-1:0]     act_p1;
    logic signed [PSUM_IN_WIDTH-1:0]  psum_p1;
    logic signed [PROD_WIDTH-1:0]     prod_p1;
    logic                             vld_p2;
    logic signed [PSUM_OUT_WIDTH-1:0] psum_p2;

    logic signed [EXT_WIDTH-1:0]      scaled_p1;
    logic signed [DATA_WIDTH-1:0]     sat_p1;
    logic signed [PSUM_OUT_WIDTH-1:0] sum_p1;

    assign scaled_p1 = rescale(prod_p1);
    assign sat_p1    = saturate(scaled_p1);
    // Both operands sign-extended to the output width, so the add cannot wrap.
    assign sum_p1    = PSUM_OUT_WIDTH'(psum_p1) + PSUM_OUT_WIDTH'(sat_p1);

    // A swap is tagged onto the beat presented with it, together with a
    // snapshot of the shadow at that edge. That beat still multiplies by the
    // old active weight; the new weight lands on the same edge as that beat's
    // product, so every later beat uses it. Snapshotting the shadow means a
    // simultaneous load cannot leak into the active weight.
    always_ff @(posedge clk_in or negedge rst_core_n) begin
        if (!rst_core_n) begin
            shadow_w  <= '0;
            active_w  <= '0;
            swap_p0   <= 1'b0;
            swap_w_p0 <= '0;
        end else if (enable) begin
            if (node.weight_valid_in) begin
                shadow_w <= node.weight_in;
            end
            swap_p0   <= node.weight_swap_in;
            swap_w_p0 <= shadow_w;
            if (swap_p0) begin
                active_w <= swap_w_p0;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_core_n) begin
        if (!rst_core_n) begin
            vld_p0  <= 1'b0;
            act_p0  <= '0;
            psum_p0 <= '0;
            vld_p1  <= 1'b0;
            act_p1  <= '0;
            psum_p1 <= '0;
            prod_p1 <= '0;
            vld_p2  <= 1'b0;
            psum_p2 <= '0;
        end else if (enable) begin
            // ---- E0: capture inputs ----
            vld_p0  <= node.act_valid_in;
            act_p0  <= node.activation_in;
            psum_p0 <= node.partial_sum_in;
            // ---- E1: full-width product, activation forward ----
            vld_p1  <= vld_p0;
            act_p1  <= act_p0;
            psum_p1 <= psum_p0;
            prod_p1 <= PROD_WIDTH'(active_w) * PROD_WIDTH'(act_p0);
            // ---- E2: rescale, saturate, accumulate ----
            vld_p2  <= vld_p1;
            psum_p2 <= sum_p1;
        end
    end

    assign node.weight_out      = shadow_w;
    assign node.act_valid_out   = vld_p1;
    assign node.activation_out  = act_p1;
    assign node.psum_valid_out  = vld_p2;
    assign node.partial_sum_out = psum_p2;

`ifdef SYSTOLIC_NODE_SAT_FLAG_EN
    logic sat_flag_q;

    // Set has priority over clear so a saturation on the clearing edge is kept.
    always_ff @(posedge clk_in or negedge rst_core_n) begin
        if (!rst_core_n) begin
            sat_flag_q <= 1'b0;
        end else if (enable) begin
            if (vld_p1 && saturates(scaled_p1)) begin
                sat_flag_q <= 1'b1;
            end else if (sat_clear_in) begin
                sat_flag_q <= 1'b0;
            end
        end
    end

    assign sat_flag_out = sat_flag_q;
`endif

endmodule

// File: tb/tb_systolic_mac_node_v2.sv
// -----------------------------------------------------------------------------
// tb_systolic_mac_node_v2
// Directed bench for systolic_mac_node_v2. Two instances share the stimulus:
// dut_t truncates on rescale, dut_r rounds half up.
// -----------------------------------------------------------------------------
module tb_systolic_mac_node_v2;
    localparam int DW = 16;
    localparam int PI = 16;
    localparam int PO = 17;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic          rst_n_in;
    logic          enable;
    logic          wv;
    logic [DW-1:0] w;
    logic          wsw;
    logic          av;
    logic [DW-1:0] act;
    logic [PI-1:0] ps;
`ifdef SYSTOLIC_NODE_SAT_FLAG_EN
    logic          sat_clear;
    logic          sat_flag_t;
    logic          sat_flag_r;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    systolic_mac_node_v2_if #(.DATA_WIDTH(DW), .PSUM_IN_WIDTH(PI), .PSUM_OUT_WIDTH(PO)) if_t ();
    systolic_mac_node_v2_if #(.DATA_WIDTH(DW), .PSUM_IN_WIDTH(PI), .PSUM_OUT_WIDTH(PO)) if_r ();

    assign if_t.enable_in       = enable;
    assign if_t.weight_valid_in = wv;
    assign if_t.weight_in       = w;
    assign if_t.weight_swap_in  = wsw;
    assign if_t.act_valid_in    = av;
    assign if_t.activation_in   = act;
    assign if_t.partial_sum_in  = ps;
    assign if_r.enable_in       = enable;
    assign if_r.weight_valid_in = wv;
    assign if_r.weight_in       = w;
    assign if_r.weight_swap_in  = wsw;
    assign if_r.act_valid_in    = av;
    assign if_r.activation_in   = act;
    assign if_r.partial_sum_in  = ps;

    systolic_mac_node_v2 #(
        .DATA_WIDTH(DW), .FRAC_BITS(10), .PSUM_IN_WIDTH(PI),
        .PSUM_OUT_WIDTH(PO), .ROUND_NEAREST(0)
    ) dut_t (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .node         (if_t)
`ifdef SYSTOLIC_NODE_SAT_FLAG_EN
        ,
        .sat_clear_in (sat_clear),
        .sat_flag_out (sat_flag_t)
`endif
    );

    systolic_mac_node_v2 #(
        .DATA_WIDTH(DW), .FRAC_BITS(10), .PSUM_IN_WIDTH(PI),
        .PSUM_OUT_WIDTH(PO), .ROUND_NEAREST(1)
    ) dut_r (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .node         (if_r)
`ifdef SYSTOLIC_NODE_SAT_FLAG_EN
        ,
        .sat_clear_in (sat_clear),
        .sat_flag_out (sat_flag_r)
`endif
    );

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        av  = 1'b0;
        act = '0;
        ps  = '0;
        wv  = 1'b0;
        w   = '0;
        wsw = 1'b0;
    endtask

    task automatic beat(input logic [DW-1:0] a, input logic [PI-1:0] p);
        av  = 1'b1;
        act = a;
        ps  = p;
    endtask

    // Load shadow, swap, and wait for the swap to land in the active weight.
    task automatic set_active(input logic [DW-1:0] val);
        idle();
        wv = 1'b1; w = val;
        tick();
        wv = 1'b0; wsw = 1'b1;
        tick();
        wsw = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        tests_run++;
        if (if_t.act_valid_out !== 1'b0) begin
            tests_failed++; $display("FAIL reset_act_valid: got %b want 0", if_t.act_valid_out);
        end
        tests_run++;
        if (if_t.activation_out !== 16'h0000) begin
            tests_failed++; $display("FAIL reset_activation: got %h want 0000", if_t.activation_out);
        end
        tests_run++;
        if (if_t.psum_valid_out !== 1'b0) begin
            tests_failed++; $display("FAIL reset_psum_valid: got %b want 0", if_t.psum_valid_out);
        end
        tests_run++;
        if (if_t.partial_sum_out !== 17'h00000) begin
            tests_failed++; $display("FAIL reset_psum: got %h want 00000", if_t.partial_sum_out);
        end
        tests_run++;
        if (if_t.weight_out !== 16'h0000) begin
            tests_failed++; $display("FAIL reset_weight_out: got %h want 0000", if_t.weight_out);
        end
`ifdef SYSTOLIC_NODE_SAT_FLAG_EN
        tests_run++;
        if (sat_flag_t !== 1'b0) begin
            tests_failed++; $display("FAIL reset_sat_flag: got %b want 0", sat_flag_t);
        end
`endif
    endtask

    task automatic test_mac();
        set_active(16'h0800);
        beat(16'h0600, 16'h0100);
        tick();
        idle();
        tick();
        tests_run++;
        if (if_t.activation_out !== 16'h0600 || if_t.act_valid_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL mac_act_out: got %h/%b want 0600/1", if_t.activation_out, if_t.act_valid_out);
        end
        tests_run++;
        if (if_t.psum_valid_out !== 1'b0) begin
            tests_failed++; $display("FAIL mac_psum_early: got valid %b want 0", if_t.psum_valid_out);
        end
        tick();
        tests_run++;
        if (if_t.partial_sum_out !== 17'h00D00 || if_t.psum_valid_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL mac_psum: got %h/%b want 00D00/1", if_t.partial_sum_out, if_t.psum_valid_out);
        end
        tests_run++;
        if (if_r.partial_sum_out !== 17'h00D00) begin
            tests_failed++; $display("FAIL mac_psum_round: got %h want 00D00", if_r.partial_sum_out);
        end
        tick();
        tests_run++;
        if (if_t.psum_valid_out !== 1'b0 || if_t.act_valid_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL mac_bubble: got valids %b/%b want 0/0", if_t.psum_valid_out, if_t.act_valid_out);
        end
    endtask

    task automatic test_saturate();
        set_active(16'h7FFF);
        beat(16'h7FFF, 16'h0000);
        tick();
        beat(16'h8000, 16'h0000);
        tick();
`ifdef SYSTOLIC_NODE_SAT_FLAG_EN
        tests_run++;
        if (sat_flag_t !== 1'b0) begin
            tests_failed++; $display("FAIL sat_flag_early: got %b want 0", sat_flag_t);
        end
        sat_clear = 1'b1;
`endif
        idle();
        tick();
        tests_run++;
        if (if_t.partial_sum_out !== 17'h07FFF || if_t.psum_valid_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL sat_pos: got %h/%b want 07FFF/1", if_t.partial_sum_out, if_t.psum_valid_out);
        end
`ifdef SYSTOLIC_NODE_SAT_FLAG_EN
        tests_run++;
        if (sat_flag_t !== 1'b1) begin
            tests_failed++; $display("FAIL sat_flag_set: got %b want 1", sat_flag_t);
        end
`endif
        tick();
        tests_run++;
        if (if_t.partial_sum_out !== 17'h18000) begin
            tests_failed++; $display("FAIL sat_neg: got %h want 18000", if_t.partial_sum_out);
        end
`ifdef SYSTOLIC_NODE_SAT_FLAG_EN
        tests_run++;
        if (sat_flag_t !== 1'b1) begin
            tests_failed++; $display("FAIL sat_flag_set_over_clear: got %b want 1", sat_flag_t);
        end
        tick();
        tests_run++;
        if (sat_flag_t !== 1'b0) begin
            tests_failed++; $display("FAIL sat_flag_clear: got %b want 0", sat_flag_t);
        end
        sat_clear = 1'b0;
`endif
    endtask

    task automatic test_rounding();
        set_active(16'h0001);
        beat(16'h0200, 16'h0000);
        tick();
        beat(16'hFE00, 16'h0000);
        tick();
        idle();
        tick();
        tests_run++;
        if (if_t.partial_sum_out !== 17'h00000) begin
            tests_failed++; $display("FAIL round_trunc_pos: got %h want 00000", if_t.partial_sum_out);
        end
        tests_run++;
        if (if_r.partial_sum_out !== 17'h00001) begin
            tests_failed++; $display("FAIL round_near_pos: got %h want 00001", if_r.partial_sum_out);
        end
        tick();
        tests_run++;
        if (if_t.partial_sum_out !== 17'h1FFFF) begin
            tests_failed++; $display("FAIL round_trunc_neg: got %h want 1FFFF", if_t.partial_sum_out);
        end
        tests_run++;
        if (if_r.partial_sum_out !== 17'h00000) begin
            tests_failed++; $display("FAIL round_near_neg: got %h want 00000", if_r.partial_sum_out);
        end
    endtask

    task automatic test_double_buffer();
        set_active(16'h0800);
        wv = 1'b1; w = 16'h0400;
        tick();
        wv = 1'b0;
        tests_run++;
        if (if_t.weight_out !== 16'h0400) begin
            tests_failed++; $display("FAIL dbuf_weight_out: got %h want 0400", if_t.weight_out);
        end
        beat(16'h0400, 16'h0000);
        tick();
        beat(16'h0400, 16'h0000); wsw = 1'b1;
        tick();
        wsw = 1'b0;
        beat(16'h0400, 16'h0000);
        tick();
        idle();
        tests_run++;
        if (if_t.partial_sum_out !== 17'h00800) begin
            tests_failed++; $display("FAIL dbuf_shadow_only: got %h want 00800", if_t.partial_sum_out);
        end
        tick();
        tests_run++;
        if (if_t.partial_sum_out !== 17'h00800) begin
            tests_failed++; $display("FAIL dbuf_swap_beat: got %h want 00800", if_t.partial_sum_out);
        end
        tick();
        tests_run++;
        if (if_t.partial_sum_out !== 17'h00400) begin
            tests_failed++; $display("FAIL dbuf_after_swap: got %h want 00400", if_t.partial_sum_out);
        end
        // Load and swap together: the old shadow (3.0) must become active.
        wv = 1'b1; w = 16'h0C00;
        tick();
        wv = 1'b1; w = 16'h0200; wsw = 1'b1;
        tick();
        idle();
        tests_run++;
        if (if_t.weight_out !== 16'h0200) begin
            tests_failed++; $display("FAIL dbuf_load_swap_shadow: got %h want 0200", if_t.weight_out);
        end
        tick();
        beat(16'h0400, 16'h0000);
        tick();
        idle();
        tick();
        tick();
        tests_run++;
        if (if_t.partial_sum_out !== 17'h00C00 || if_t.psum_valid_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL dbuf_load_swap_active: got %h/%b want 00C00/1", if_t.partial_sum_out, if_t.psum_valid_out);
        end
    endtask

    task automatic test_stall();
        logic [DW-1:0] acts [4];
        logic [PI-1:0] sums [4];
        logic [PO-1:0] exp_out [4];
        logic [PO-1:0] snap_psum;
        logic          snap_pv;
        logic [DW-1:0] snap_act;
        logic          snap_av;
        int            sent;
        int            got;
        logic          en;
        acts    = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
        sums    = '{16'h0010, 16'h0020, 16'h0030, 16'h0040};
        exp_out = '{17'h00210, 17'h00420, 17'h00630, 17'h00840};
        sent = 0;
        got  = 0;
        set_active(16'h0800);
        for (int c = 0; c < 20; c++) begin
            en = !(c >= 3 && c < 7);
            if (sent < 4) beat(acts[sent], sums[sent]);
            else idle();
            enable    = en;
            snap_psum = if_t.partial_sum_out;
            snap_pv   = if_t.psum_valid_out;
            snap_act  = if_t.activation_out;
            snap_av   = if_t.act_valid_out;
            tick();
            if (en && sent < 4) sent++;
            if (!en) begin
                tests_run++;
                if (if_t.partial_sum_out !== snap_psum || if_t.psum_valid_out !== snap_pv ||
                    if_t.activation_out !== snap_act || if_t.act_valid_out !== snap_av) begin
                    tests_failed++;
                    $display("FAIL stall_frozen c=%0d: got %h/%b %h/%b want %h/%b %h/%b", c,
                             if_t.partial_sum_out, if_t.psum_valid_out, if_t.activation_out,
                             if_t.act_valid_out, snap_psum, snap_pv, snap_act, snap_av);
                end
            end else if (if_t.psum_valid_out === 1'b1) begin
                tests_run++;
                if (got >= 4) begin
                    tests_failed++; $display("FAIL stall_extra_beat: got %h want none", if_t.partial_sum_out);
                end else if (if_t.partial_sum_out !== exp_out[got]) begin
                    tests_failed++;
                    $display("FAIL stall_beat%0d: got %h want %h", got, if_t.partial_sum_out, exp_out[got]);
                end
                got++;
            end
        end
        enable = 1'b1;
        idle();
        tests_run++;
        if (got != 4) begin
            tests_failed++; $display("FAIL stall_beat_count: got %0d want 4", got);
        end
    endtask

    task automatic test_reset_midstream();
        set_active(16'h0800);
        beat(16'h0600, 16'h0100);
        tick();
        tick();
        tick();
        #2;
        rst_n_in = 1'b0;
        #1;
        tests_run++;
        if (if_t.psum_valid_out !== 1'b0 || if_t.partial_sum_out !== 17'h00000 ||
            if_t.act_valid_out !== 1'b0 || if_t.activation_out !== 16'h0000) begin
            tests_failed++;
            $display("FAIL rst_mid_outputs: got %h/%b %h/%b want 00000/0 0000/0",
                     if_t.partial_sum_out, if_t.psum_valid_out, if_t.activation_out, if_t.act_valid_out);
        end
        tests_run++;
        if (if_t.weight_out !== 16'h0000) begin
            tests_failed++; $display("FAIL rst_mid_weight: got %h want 0000", if_t.weight_out);
        end
        idle();
        tick();
        tick();
        #2;
        rst_n_in = 1'b1;
        tick();
        tick();
        tick();
        // Weights were discarded, so the product is 0 and the sum is the psum.
        beat(16'h0600, 16'h0100);
        tick();
        idle();
        tick();
        tests_run++;
        if (if_t.psum_valid_out !== 1'b0) begin
            tests_failed++; $display("FAIL rst_mid_early: got valid %b want 0", if_t.psum_valid_out);
        end
        tick();
        tests_run++;
        if (if_t.partial_sum_out !== 17'h00100 || if_t.psum_valid_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_mid_first_beat: got %h/%b want 00100/1", if_t.partial_sum_out, if_t.psum_valid_out);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_in = 1'b0;
        enable   = 1'b1;
`ifdef SYSTOLIC_NODE_SAT_FLAG_EN
        sat_clear = 1'b0;
`endif
        idle();
        repeat (3) tick();
        rst_n_in = 1'b1;
        repeat (3) tick();
        test_reset();
        test_mac();
        test_saturate();
        test_rounding();
        test_double_buffer();
        test_stall();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
